// File: rtl/ycr1_imem_ahb_sram_if.sv
// ----------------------------------------------------------------------------
// ycr1_imem_ahb_sram_if
//   Bundles the AHB-Lite instruction-fetch bus and the program-memory SRAM
//   port that together form the boundary of ycr1_imem_ahb_sram.
//
//   Bus side (master -> slave):  hsel, htrans, haddr, hsize, hwrite, hready_in
//   Bus side (slave -> master):  hready_out, hresp, hrdata
//   SRAM side (slave -> SRAM):   sram_en, sram_addr
//   SRAM side (SRAM -> slave):   sram_rdata
//
//   The "master" modport is the environment view: it drives the AHB request
//   and returns the SRAM read data.
// ----------------------------------------------------------------------------
interface ycr1_imem_ahb_sram_if #(
  parameter int AHB_AW = 32,
  parameter int MEM_AW = 10
);

  logic              hsel;
  logic [1:0]        htrans;
  logic [AHB_AW-1:0] haddr;
  logic [2:0]        hsize;
  logic              hwrite;
  logic              hready_in;
  logic              hready_out;
  logic              hresp;
  logic [AHB_AW-1:0] hrdata;
  logic              sram_en;
  logic [MEM_AW-1:0] sram_addr;
  logic [AHB_AW-1:0] sram_rdata;

  modport slave (
    input  hsel, htrans, haddr, hsize, hwrite, hready_in, sram_rdata,
    output hready_out, hresp, hrdata, sram_en, sram_addr
  );

  modport master (
    output hsel, htrans, haddr, hsize, hwrite, hready_in, sram_rdata,
    input  hready_out, hresp, hrdata, sram_en, sram_addr
  );

endinterface

// File: rtl/ycr1_imem_ahb_sram.sv
// ----------------------------------------------------------------------------
// ycr1_imem_ahb_sram
//   Read-only AHB-Lite slave in front of a synchronous single-port program
//   memory. Legal word reads fire a one-cycle SRAM enable in the address
//   phase and complete WAIT_CYCLES+1 cycles later. Writes, non-word sizes,
//   misaligned and out-of-range addresses never touch the SRAM and receive
//   the two-cycle AHB ERROR response.
//
//   Ports:
//     clk  - core clock, all state changes on the rising edge
//     rst  - synchronous active-high reset
//     bus  - ycr1_imem_ahb_sram_if.slave: AHB request/response plus SRAM port
//
//   Parameters:
//     AHB_AW      - AHB address/data width
//     MEM_DEPTH   - SRAM depth in 32-bit words
//     MEM_AW      - SRAM word-address width (>= $clog2(MEM_DEPTH))
//     WAIT_CYCLES - extra data-phase stall cycles per read (0..15)
// ----------------------------------------------------------------------------
module ycr1_imem_ahb_sram #(
  parameter int AHB_AW      = 32,
  parameter int MEM_DEPTH   = 1024,
  parameter int MEM_AW      = 10,
  parameter int WAIT_CYCLES = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  ycr1_imem_ahb_sram_if.slave     bus
);

  // wait counter needs at least one bit even when no wait states are used
  localparam int                WCW       = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam logic [WCW-1:0]    WAIT_LOAD = WCW'(WAIT_CYCLES);
  localparam logic [WCW-1:0]    CNT_ZERO  = {WCW{1'b0}};
  localparam logic [WCW-1:0]    CNT_ONE   = {{(WCW-1){1'b0}}, 1'b1};
  localparam logic [AHB_AW-1:0] DEPTH_W   = AHB_AW'(MEM_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_DATA = 2'b01,
    ST_ERR1 = 2'b10,
    ST_ERR2 = 2'b11
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [WCW-1:0]      r_wait_cnt;
  logic [WCW-1:0]      w_wait_cnt_nxt;
  logic                r_hready_out;
  logic                r_hresp;
  logic                w_hready_nxt;
  logic                w_hresp_nxt;

  logic                w_acc;
  logic                w_illegal;
  logic                w_complete;
  logic                w_addr_slot;
  logic                w_start_rd;
  logic                w_start_err;
  logic [AHB_AW-1:0]   w_word_idx;

  // Address-phase decode. A new transfer may only be taken when the slave is
  // idle, finishing a read, or in the final ERROR cycle; reset blocks it so no
  // SRAM access is launched while the block is being cleared.
  assign w_word_idx  = {2'b00, bus.haddr[AHB_AW-1:2]};
  assign w_acc       = bus.hsel & bus.htrans[1] & bus.hready_in;
  assign w_illegal   = bus.hwrite
                     | (bus.hsize != 3'b010)
                     | (bus.haddr[1:0] != 2'b00)
                     | (w_word_idx >= DEPTH_W);
  assign w_complete  = (r_state == ST_DATA) & (r_wait_cnt == CNT_ZERO);
  assign w_addr_slot = (r_state == ST_IDLE) | (r_state == ST_ERR2) | w_complete;
  assign w_start_rd  = ~rst & w_addr_slot & w_acc & ~w_illegal;
  assign w_start_err = ~rst & w_addr_slot & w_acc &  w_illegal;

  // SRAM read is launched in the same cycle as the accepted address phase
  assign bus.sram_en   = w_start_rd;
  assign bus.sram_addr = w_start_rd ? bus.haddr[MEM_AW+1:2] : {MEM_AW{1'b0}};

  // Read data is only presented in the completion cycle; SRAM data is held
  // stable there because no new enable has been issued since the launch.
  assign bus.hrdata     = w_complete ? bus.sram_rdata : {AHB_AW{1'b0}};
  assign bus.hready_out = r_hready_out;
  assign bus.hresp      = r_hresp;

  // Next-state and wait-counter logic for the transfer FSM
  always_comb begin
    w_state_nxt    = r_state;
    w_wait_cnt_nxt = r_wait_cnt;
    case (r_state)
      ST_IDLE, ST_ERR2: begin
        if (w_start_rd) begin
          w_state_nxt    = ST_DATA;
          w_wait_cnt_nxt = WAIT_LOAD;
        end else if (w_start_err) begin
          w_state_nxt    = ST_ERR1;
        end else begin
          w_state_nxt    = ST_IDLE;
        end
      end
      ST_DATA: begin
        if (r_wait_cnt != CNT_ZERO) begin
          w_wait_cnt_nxt = r_wait_cnt - CNT_ONE;
        end else if (w_start_rd) begin
          // pipelined address phase overlapping the completion cycle
          w_wait_cnt_nxt = WAIT_LOAD;
        end else if (w_start_err) begin
          w_state_nxt    = ST_ERR1;
        end else begin
          w_state_nxt    = ST_IDLE;
        end
      end
      ST_ERR1: begin
        // second ERROR cycle always follows; the master's next request is ignored
        w_state_nxt = ST_ERR2;
      end
      default: begin
        w_state_nxt    = ST_IDLE;
        w_wait_cnt_nxt = CNT_ZERO;
      end
    endcase
  end

  // Response flags for the upcoming cycle, derived from the next state so the
  // outputs can be registered without adding latency
  always_comb begin
    w_hready_nxt = 1'b1;
    w_hresp_nxt  = 1'b0;
    case (w_state_nxt)
      ST_DATA: begin
        w_hready_nxt = (w_wait_cnt_nxt == CNT_ZERO);
        w_hresp_nxt  = 1'b0;
      end
      ST_ERR1: begin
        w_hready_nxt = 1'b0;
        w_hresp_nxt  = 1'b1;
      end
      ST_ERR2: begin
        w_hready_nxt = 1'b1;
        w_hresp_nxt  = 1'b1;
      end
      default: begin
        w_hready_nxt = 1'b1;
        w_hresp_nxt  = 1'b0;
      end
    endcase
  end

  // State, wait counter and registered response flags
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_wait_cnt   <= CNT_ZERO;
      r_hready_out <= 1'b1;
      r_hresp      <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_wait_cnt   <= w_wait_cnt_nxt;
      r_hready_out <= w_hready_nxt;
      r_hresp      <= w_hresp_nxt;
    end
  end

endmodule

// File: tb/tb_ycr1_imem_ahb_sram.sv
// ----------------------------------------------------------------------------
// tb_ycr1_imem_ahb_sram
//   Three instances (WAIT_CYCLES = 0, 2, 3), each with its own SRAM model,
//   driver and monitor. The driver issues a directed preamble followed by
//   random transfers and pushes the expected per-cycle bus response and SRAM
//   enable into queues; the monitor pops and compares every cycle.
// ----------------------------------------------------------------------------
module tb_ycr1_imem_ahb_sram;

  localparam int AW    = 32;
  localparam int DEPTH = 1024;
  localparam int MAW   = 10;
  localparam int NCYC  = 1500;
  localparam int NPLAN = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total  = 0;
  int bad    = 0;
  int n_done = 0;

  typedef struct packed {
    logic        rdy;
    logic        resp;
    logic [31:0] data;
  } rsp_t;

  typedef struct packed {
    logic           en;
    logic [MAW-1:0] addr;
  } en_t;

  // directed preamble: {hwrite, hsize, haddr}
  logic [35:0] plan [NPLAN] = '{
    {1'b0, 3'b010, 32'h0000_0014},
    {1'b0, 3'b010, 32'h0000_0000},
    {1'b0, 3'b010, 32'h0000_0004},
    {1'b0, 3'b010, 32'h0000_0008},
    {1'b0, 3'b010, 32'h0000_1000},
    {1'b1, 3'b010, 32'h0000_0000},
    {1'b0, 3'b001, 32'h0000_0000},
    {1'b0, 3'b010, 32'h0000_0002},
    {1'b0, 3'b010, 32'h0000_0008},
    {1'b0, 3'b010, 32'h0000_0FFC}
  };

  task automatic chk(input string name, input int w, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s (W=%0d) t=%0t: got %h expected %h", name, w, $time, act, exp);
    end
  endtask

  for (genvar g = 0; g < 3; g++) begin : g_inst
    localparam int W = (g == 0) ? 0 : ((g == 1) ? 2 : 3);

    logic        rst;
    logic        drv_done = 1'b0;
    logic [31:0] mem [0:DEPTH-1];
    rsp_t        exp_q [$];
    en_t         en_q  [$];

    ycr1_imem_ahb_sram_if #(.AHB_AW(AW), .MEM_AW(MAW)) bus ();

    ycr1_imem_ahb_sram #(
      .AHB_AW(AW), .MEM_DEPTH(DEPTH), .MEM_AW(MAW), .WAIT_CYCLES(W)
    ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
    );

    // synchronous SRAM: data valid the cycle after the enable, held otherwise
    always @(posedge clk) begin
      if (rst === 1'b1 && bus.sram_rdata === 32'bx) bus.sram_rdata <= 32'h0;
      else if (bus.sram_en) bus.sram_rdata <= mem[bus.sram_addr];
    end

    // driver + reference model
    initial begin
      int          pend;
      int          plan_i;
      int          n_rst;
      int          r;
      logic [35:0] p;
      logic [31:0] a;
      logic [2:0]  hs;
      logic [1:0]  ht;
      logic        hw, sel, hri, cur_ready, was_busy, acc, legal;

      for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
      mem[5] = 32'hDEAD_BEEF;
      rst = 1'b1;
      bus.hsel = 1'b0; bus.htrans = 2'b00; bus.haddr = 32'h0;
      bus.hsize = 3'b010; bus.hwrite = 1'b0; bus.hready_in = 1'b1;
      bus.sram_rdata = 32'h0;
      pend = 0; plan_i = 0; n_rst = 0;
      @(posedge clk);
      for (int c = 0; c < NCYC; c++) begin
        @(negedge clk); #2;
        was_busy = (pend > 0);
        if (pend > 0) pend--;
        cur_ready = (pend == 0);
        sel = 1'b0; ht = 2'b00; a = 32'h0; hs = 3'b010; hw = 1'b0; hri = 1'b1;
        if (c < 4) begin
          // reset with a legal request on the bus: no SRAM access may start
          rst = 1'b1; sel = 1'b1; ht = 2'b10;
          a = 32'($urandom_range(0, DEPTH - 1)) << 2;
        end else if (!cur_ready && n_rst < 3 && c > 100 && $urandom_range(0, 99) < 8) begin
          // reset in the middle of a wait or ERROR cycle drops the response
          rst = 1'b1; n_rst++; pend = 0; exp_q.delete();
          sel = 1'b1; ht = 2'b10; a = 32'h10;
        end else begin
          rst = 1'b0;
          if (cur_ready) begin
            sel = 1'b1; ht = 2'b10;
            if (plan_i < NPLAN) begin
              p = plan[plan_i]; plan_i++;
              hw = p[35]; hs = p[34:32]; a = p[31:0];
            end else begin
              r = $urandom_range(0, 99);
              ht = ($urandom_range(0, 1) == 0) ? 2'b10 : 2'b11;
              a  = 32'($urandom_range(0, DEPTH - 1)) << 2;
              if (r < 10)      sel = 1'b0;
              else if (r < 18) ht = 2'($urandom_range(0, 1));
              else if (r < 22) hw = 1'b1;
              else if (r < 26) hs = 3'($urandom_range(0, 7));
              else if (r < 30) a[1:0] = 2'($urandom_range(1, 3));
              else if (r < 35) a = (32'($urandom) | 32'h0000_1000) & 32'hFFFF_FFFC;
              if (!was_busy && $urandom_range(0, 99) < 10) hri = 1'b0;
            end
          end else begin
            // slave is stalling the bus: whatever the master shows is ignored
            sel = 1'($urandom_range(0, 1)); ht = 2'($urandom_range(0, 3));
            a = 32'($urandom); hri = 1'b0;
          end
        end
        bus.hsel = sel; bus.htrans = ht; bus.haddr = a;
        bus.hsize = hs; bus.hwrite = hw; bus.hready_in = hri;

        acc   = !rst && cur_ready && sel && ht[1] && hri;
        legal = !hw && (hs == 3'b010) && (a % 4 == 0) && (a < 32'(DEPTH * 4));
        if (acc && legal) begin
          for (int k = 0; k < W; k++) exp_q.push_back({1'b0, 1'b0, 32'h0});
          exp_q.push_back({1'b1, 1'b0, mem[a / 4]});
          pend = W + 1;
          en_q.push_back({1'b1, MAW'(a / 4)});
        end else begin
          if (acc) begin
            exp_q.push_back({1'b0, 1'b1, 32'h0});
            exp_q.push_back({1'b1, 1'b1, 32'h0});
            pend = 2;
          end
          en_q.push_back({1'b0, {MAW{1'b0}}});
        end
      end
      drv_done = 1'b1;
    end

    // monitor: compare bus response and SRAM enable every cycle
    initial begin
      rsp_t e;
      en_t  f;
      @(posedge clk);
      while (!drv_done) begin
        @(negedge clk); #1;
        if (exp_q.size() > 0) e = exp_q.pop_front();
        else                  e = {1'b1, 1'b0, 32'h0};
        chk("hready_out", W, 32'(bus.hready_out), 32'(e.rdy));
        chk("hresp",      W, 32'(bus.hresp),      32'(e.resp));
        chk("hrdata",     W, bus.hrdata,          e.data);
        #2;
        if (en_q.size() > 0) begin
          f = en_q.pop_front();
          chk("sram_en",   W, 32'(bus.sram_en),   32'(f.en));
          chk("sram_addr", W, 32'(bus.sram_addr), 32'(f.addr));
        end else begin
          chk("en_expectation_present", W, 32'(en_q.size()), 32'd1);
        end
      end
      n_done++;
    end
  end

  initial begin
    fork
      begin
        wait (n_done == 3);
      end
      begin
        #200000;
        total++; bad++;
        $display("FAIL timeout: got %0d finished instances expected 3", n_done);
      end
    join_any
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ycr1_imem_ahb_sram.md
Name: ycr1_imem_ahb_sram

Overview:
- AHB-Lite read-only slave in front of a synchronous single-port program-memory SRAM macro.
- Sits directly downstream of the core's instruction-memory AHB bridge and consumes its htrans/haddr/hsize stream.
- Returns hrdata with programmable wait states.
- Flags illegal accesses (out-of-range, writes, misaligned, non-word) with the standard two-cycle AHB ERROR response.

Parameters:
- AHB_AW, 32, AHB address/data width.
- MEM_DEPTH, 1024, SRAM depth in 32-bit words; word index >= MEM_DEPTH is an error.
- MEM_AW, 10, SRAM word-address width; must be >= $clog2(MEM_DEPTH).
- WAIT_CYCLES, 0, extra data-phase cycles with hready_out low before a read completes (0..15).

Ports:
- clk  input  1  core clock; all logic on posedge.
- rst  input  1  synchronous active-high reset.
- hsel  input  1  slave select.
- htrans  input  2  AHB transfer type (IDLE=00, BUSY=01, NONSEQ=10, SEQ=11).
- haddr  input  AHB_AW  byte address.
- hsize  input  3  transfer size; only 3'b010 (word) is legal.
- hwrite  input  1  write request; always illegal.
- hready_in  input  1  bus-level hready; transfer sampled only when high.
- hready_out  output  1  slave ready.
- hresp  output  1  0=OKAY, 1=ERROR.
- hrdata  output  AHB_AW  read data.
- sram_en  output  1  SRAM read enable (one-cycle pulse).
- sram_addr  output  MEM_AW  SRAM word address.
- sram_rdata  input  AHB_AW  SRAM data, valid the cycle after sram_en and held until the next sram_en.

Behaviour:
- Interface: single clock clk; reset rst is synchronous, active-high.
- Reset values: state=IDLE, hready_out=1, hresp=0, hrdata=0, sram_en=0, wait_cnt=0.
- Accept condition: acc = hsel & htrans[1] & hready_in.
- Transfers with htrans IDLE/BUSY, or hsel=0, get a zero-wait OKAY and leave state unchanged.
- Legality check on acc: illegal = hwrite | (hsize!=3'b010) | (haddr[1:0]!=0) | (haddr[AHB_AW-1:2] >= MEM_DEPTH).
- Legal acc:
  - sram_en=1 combinationally in the address-phase cycle.
  - sram_addr=haddr[MEM_AW+1:2].
  - wait_cnt loaded with WAIT_CYCLES; state->DATA.
- Illegal acc: sram_en=0; state->ERR1. The SRAM is never accessed.
- sram_addr is haddr[MEM_AW+1:2] when sram_en=1, else 0.
- States:
  - IDLE: hready_out=1, hresp=0, hrdata=0. On acc -> DATA or ERR1 as above.
  - DATA:
    - While wait_cnt!=0: hready_out=0, hresp=0, hrdata=0, wait_cnt decrements by 1 per cycle. sram_en stays 0, so sram_rdata holds.
    - When wait_cnt==0: hready_out=1, hresp=0, hrdata=sram_rdata; this is the completion cycle.
    - Same completion cycle: a new acc (pipelined address phase) goes -> DATA (reload wait_cnt, sram_en=1) or ERR1.
    - No acc on completion -> IDLE.
  - ERR1: hready_out=0, hresp=1, hrdata=0; unconditionally -> ERR2. Address phase is stalled by hready_in=0.
  - ERR2: hready_out=1, hresp=1, hrdata=0. On acc -> DATA or ERR1; else -> IDLE.
- Latency:
  - Legal read data is returned (hready_out=1) exactly WAIT_CYCLES+1 cycles after the address-phase edge.
  - With WAIT_CYCLES=0, back-to-back NONSEQ reads sustain one word per cycle.
- Error response is always exactly two cycles.
- The master dropping htrans to IDLE during ERR1 is legal and ignored; the response still completes.
- wait_cnt width is $clog2(WAIT_CYCLES+1), minimum 1 bit. It never underflows: decrement only when !=0.
- Reset asserted mid-DATA or mid-ERR:
  - Next cycle state=IDLE, hready_out=1, hresp=0.
  - The pending response is dropped and no sram_en is issued during reset.
- hready_in=0 while this slave is in IDLE (another slave stalling): no accept, no sram_en.
- Illegal values of the encoded state -> IDLE.

Test Plan:
- WAIT_CYCLES=0, SRAM word 5 = 0xDEADBEEF; NONSEQ read haddr=0x14 -> sram_en=1/sram_addr=5 in the address cycle; next cycle hready_out=1, hresp=0, hrdata=0xDEADBEEF.
- WAIT_CYCLES=0; NONSEQ reads to 0x0, 0x4, 0x8 on consecutive cycles -> hrdata of words 0, 1, 2 on three consecutive cycles, hready_out constantly 1.
- WAIT_CYCLES=2; read haddr=0x8 -> hready_out low for 2 cycles, then high with word 2; a second read in the completion cycle repeats the 2-wait pattern.
- MEM_DEPTH=1024; read haddr=0x1000 -> sram_en never asserted; cycle1 hready_out=0/hresp=1, cycle2 hready_out=1/hresp=1, then IDLE OKAY.
- hwrite=1 at 0x0, then hsize=3'b001 read at 0x0, then read at 0x2 -> each gets the two-cycle ERROR; a following legal read returns correct data.
- WAIT_CYCLES=3; assert rst for one cycle in the 2nd wait cycle -> next cycle hready_out=1, hresp=0, hrdata=0; state IDLE; a fresh read then completes normally.
